// File: rtl/xls_unroll_result_collector.sv
// xls_unroll_result_collector
//   Ready/valid wrapper around a fixed-latency, non-stallable pipeline.
//   Accepted operands are forwarded to the pipeline. A LATENCY-deep valid
//   line marks which pipeline results are real, and those results are
//   captured into a DEPTH-entry FIFO. Upstream is throttled by credit
//   counting, so a result never arrives at a full FIFO.
//
// Ports
//   clk, rst   clock and asynchronous active-high reset
//   in_valid   upstream operand valid
//   in_data    upstream operand
//   in_ready   operand accepted this cycle when in_valid is also high
//   pipe_x     operand to the pipeline (copy of in_data)
//   pipe_out   result from the pipeline
//   out_valid  result FIFO non-empty
//   out_data   FIFO head
//   out_ready  downstream takes the head
//   occupancy  in-flight operands plus buffered results
module xls_unroll_result_collector #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 6,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           pipe_x,
  input  logic [WIDTH-1:0]           pipe_out,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

  logic [LATENCY-1:0] vline;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [OW-1:0]      fifo_count;
  logic               acc;
  logic               push;
  logic               pop;

  // Modulo-DEPTH increment, so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Credit comes from registered occupancy only; a pop in the same cycle
  // does not open the door early.
  assign in_ready  = (occupancy < DEPTH_OCC);
  assign acc       = in_valid & in_ready;
  assign pipe_x    = in_data;
  assign push      = vline[LATENCY-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vline      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      occupancy  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      vline[0] <= acc;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vline[i] <= vline[i-1];
      end

      if (push) begin
        mem[wr_ptr] <= pipe_out;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end

      if (acc && !pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (pop && !acc) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

endmodule

// File: doc/xls_unroll_result_collector.md
Name: xls_unroll_result_collector

Overview:
- Downstream companion to the xlscc-generated unrolled multiply-accumulate pipeline. That pipeline has a fixed latency of 6 cycles, no valid, no stall, no reset, and computes out = x*496 mod 2^32.
- This block adds ready/valid flow control around the pipeline:
  - drives the pipeline input from an upstream handshake;
  - tracks in-flight valid bits through a LATENCY-deep shift line;
  - captures emerging results into a DEPTH-entry FIFO;
  - backpressures upstream by credit counting, because the pipeline cannot stall.

Parameters:
- WIDTH, 32, data width of pipeline input and result.
- LATENCY, 6, clock edges from pipeline x sampled to result on pipeline out; must be >= 1.
- DEPTH, 8, result FIFO entries; must be >= 1.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream request valid.
- in_data  input  WIDTH  upstream operand x.
- in_ready  output  1  block can accept in_data this cycle.
- pipe_x  output  WIDTH  to pipeline x; combinational copy of in_data.
- pipe_out  input  WIDTH  from pipeline out.
- out_valid  output  1  result FIFO non-empty.
- out_data  output  WIDTH  FIFO head.
- out_ready  input  1  downstream accepts head.
- occupancy  output  clog2(DEPTH+1)  in-flight count plus FIFO count.

Behaviour:
- Reset (async assert, sync release) clears:
  - the valid shift line;
  - FIFO read/write pointers and count;
  - occupancy.
- Reset output values:
  - in_ready=1 (occupancy 0 < DEPTH);
  - out_valid=0;
  - out_data=0 (FIFO storage cleared);
  - occupancy=0.
- Accept: acc = in_valid & in_ready. Define in_ready = (occupancy < DEPTH), computed from registered occupancy only. A same-cycle pop does not grant extra credit.
- pipe_x = in_data every cycle, regardless of acc; the pipeline computes garbage on unaccepted cycles and the block ignores it.
- Valid line: vline[0] <= acc; vline[i] <= vline[i-1]. When vline[LATENCY-1] is set, the value on pipe_out that cycle belongs to the operand accepted LATENCY edges earlier. With the LATENCY=6 pipeline, x accepted at edge t produces pipe_out valid in the cycle after edge t+5, which is exactly when vline[5] is high.
- Push: when vline[LATENCY-1]=1, write pipe_out at wr_ptr and increment the pointer, wrapping DEPTH-1 -> 0. Pointers use modulo-DEPTH arithmetic so non-power-of-two DEPTH works.
- Pop: out_valid & out_ready; increment rd_ptr with the same wrap. No bypass: a pushed result is visible on out_valid the cycle after the push.
- End-to-end latency: in_valid accepted at edge t gives out_valid=1 after edge t+LATENCY, i.e. LATENCY+1 cycles after acceptance.
- Occupancy next value:
  - acc & !pop: +1;
  - pop & !acc: -1;
  - both or neither: unchanged.
  - Never exceeds DEPTH, so a push into a full FIFO is structurally impossible. The bench asserts this.
- Push and pop in the same cycle: both occur, FIFO count unchanged. This is legal even when the FIFO count equals DEPTH at the time of the pop.
- Throughput: one result per cycle sustained while out_ready=1 and DEPTH >= LATENCY+1. With smaller DEPTH, throughput is credit-limited to DEPTH/(LATENCY+1).
- Reset mid-operation: in-flight and buffered results are discarded. Garbage still emerging from the unreset pipeline is ignored because vline is cleared.
- Ordering: results leave in acceptance order. No reordering or dropping.

Test Plan:
- Single op: reset, then in_data=1 for one accepted cycle, out_ready=1 -> out_valid rises 7 cycles after acceptance with out_data=0x000001F0; occupancy 1 during flight, 0 after pop.
- Streaming: 20 back-to-back x=0..19, out_ready=1, DEPTH=8 -> outputs 0,496,...,9424 in order; in_ready stays 1 (occupancy peaks at 7); no gaps after the first output.
- Backpressure: out_ready=0, offer 12 ops -> exactly 8 accepted, in_ready=0 with occupancy=8. Then out_ready=1 -> 8 results pop in order, and in_ready reasserts the cycle after the first pop.
- Wrap and simultaneous: DEPTH=3, alternate out_ready 1/0 over 30 ops with x=0xFFFFFFFF -> every result is 0xFFFFFE10; pointers wrap correctly; no loss or duplication.
- Reset mid-flight: accept 4 ops, assert rst 3 cycles later for 1 cycle -> out_valid stays 0 and occupancy=0 afterwards; the next accepted x=2 yields 0x3E0.
- Idle garbage: in_valid=0 for 50 cycles with in_data toggling randomly -> out_valid never asserts.
